hinge_loss_bwd: RTL and testbench
=================================

# hinge_loss_bwd

Streaming backward pass for the hinge-loss operator: computes d(loss)/d(pred) per element for mean(max(0, 1 - pred*target)) over fixed-length frames. It consumes the same (prediction, target) stream as the forward hinge-loss block, plus the upstream scalar gradient. It emits one gradient word per element with valid/ready flow control and a frame-end marker. It sits between the loss stage and the gradient writeback path.

## Interface
- DATA_W, 32: word width; pred, grad_in, grad_out are signed fixed-point Q(DATA_W-16).16.
- LOG2_N, 4: frame length N = 2^LOG2_N elements; 1 <= LOG2_N <= 16.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- valid_in  in  1  input element valid.
- ready_in  out  1  block accepts an element this cycle.
- pred_in  in  DATA_W  prediction, signed Q.16.
- target_pos  in  1  target label: 1 = +1, 0 = -1.
- grad_in  in  DATA_W  upstream scalar gradient, signed Q.16; sampled on the first beat of each frame.
- valid_out  out  1  gradient word valid.
- ready_out  in  1  downstream accepts.
- grad_out  out  DATA_W  d(loss)/d(pred), signed Q.16.
- last_out  out  1  marks element N-1 of a frame; qualified by valid_out.
- viol_count  out  LOG2_N+1  number of margin-violating elements in the last completed frame.
- count_valid  out  1  one-cycle pulse when viol_count updates.

## Operation
- Input beat = valid_in && ready_in. Output beat = valid_out && ready_out.
- Frame FSM: IDLE (idx = 0, no frame open) -> RUN on an input beat. In RUN, idx increments on each input beat. On the input beat with idx == N-1, idx -> 0 and the state -> IDLE. Back-to-back frames carry no bubble.
- The grad_in capture register loads on an input beat taken in IDLE. It holds for the whole frame.
- Margin: m = ONE - (target_pos ? pred : -pred), computed in DATA_W+2 bits with no overflow. ONE = 1 << 16.
- Active iff m > 0. m == 0 is inactive.
- Gradient: active ? ((target_pos ? -g : g) >>> LOG2_N) : 0.
  - >>> is an arithmetic shift, rounding toward negative infinity.
  - -g is computed in DATA_W+1 bits before the shift, so g = most-negative value does not wrap.
  - The result is truncated to DATA_W bits. The result always fits.
- last_out = 1 on the output word of element N-1.
- Violation counter counts active elements as they retire at the output.
  - On the output beat carrying last_out: viol_count <= final count, count_valid pulses for 1 cycle, and the accumulator clears.
- Reset mid-frame: the partial frame is discarded, the pipeline is flushed, idx = 0, the state -> IDLE, and there is no count_valid.

## Timing
- Pipeline of 2 register stages: S1 holds margin sign, captured g, and sign select; S2 holds the shifted result.
- Latency: 2 cycles from input beat to valid_out when unstalled.
- Throughput: 1 element per cycle.
- Stall rule: advance = !valid_out || ready_out; ready_in = advance && !rst.
  - The whole pipeline freezes while valid_out && !ready_out.
  - grad_out and last_out stay stable while stalled.
- Reset values: ready_in 0 during rst, valid_out 0, grad_out 0, last_out 0, viol_count 0, count_valid 0.
- Simultaneous events:
  - A count_valid pulse and the first accepted beat of the next frame may occur in the same cycle. The new frame's count starts from 0 plus that beat's contribution, if the beat retires.
- count_valid asserts in the cycle after the output beat that carries last_out.

## Configuration
- HINGE_BWD_VIOL_CNT_EN
  - Defined: the violation counter, viol_count, and count_valid are built as described.
  - Undefined: the counter logic is removed, and viol_count and count_valid are tied to 0. Gradient datapath and timing are unchanged.

## Test plan
The stimulus uses LOG2_N=2 (N=4), grad_in=0x00010000, and ready_out=1 unless stated otherwise.
- Basic frame: inputs (pred, target_pos) = (0x00008000,1), (0x00010000,1), (0xFFFE0000,0), (0x00004000,0).
  - grad_out = 0xFFFFC000, 0, 0, 0x00004000.
  - last_out on the 4th word; viol_count=2 with count_valid 1 cycle later. First valid_out 2 cycles after the first beat.
- Backpressure: same frame, ready_out=0 for 3 cycles after the first valid_out.
  - grad_out holds 0xFFFFC000 and ready_in=0 during the stall.
  - No element is lost or duplicated; the output order is unchanged.
- grad_in capture: change grad_in to 0x00040000 mid-frame.
  - The current frame still uses 1.0.
  - The next frame's active (0x00008000,1) gives 0xFFFF0000.
- Extreme g: grad_in=0x80000000, element (0,0) active.
  - grad_out = 0xE0000000, with no wrap.
  - Element (0,1) gives 0x20000000.
- Reset mid-frame: assert rst after 2 input beats.
  - All outputs go to 0 and there is no count_valid.
  - A following full frame yields its own correct viol_count and last_out on its 4th word.
- Macro off: rebuild without HINGE_BWD_VIOL_CNT_EN and rerun the basic frame.
  - grad_out is identical to the basic-frame results.
  - viol_count and count_valid stay 0.

Source files
------------

// File: rtl/hinge_loss_bwd.sv
// Streaming hinge-loss backward pass: per-element d(loss)/d(pred) over 2^LOG2_N frames.
// Optional violation counter is built when HINGE_BWD_VIOL_CNT_EN is defined.
module hinge_loss_bwd #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LOG2_N = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic [DATA_W-1:0] pred_in,
  input  logic              target_pos,
  input  logic [DATA_W-1:0] grad_in,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [DATA_W-1:0] grad_out,
  output logic              last_out,
  output logic [LOG2_N:0]   viol_count,
  output logic              count_valid
);

  localparam int unsigned EXT_W    = DATA_W + 2;
  localparam int unsigned GX_W     = DATA_W + 1;
  localparam int unsigned CNT_W    = LOG2_N + 1;
  localparam int unsigned IDX_LAST = (1 << LOG2_N) - 1;
  localparam logic [EXT_W-1:0] ONE_EXT = EXT_W'(65536);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state;
  logic [LOG2_N-1:0]   idx;
  logic [DATA_W-1:0]   g_reg;

  logic                s1_valid;
  logic                s1_active;
  logic                s1_neg;
  logic                s1_last;
  logic [DATA_W-1:0]   s1_g;

  logic                advance;
  logic                in_beat;
  logic                is_last_idx;
  logic [DATA_W-1:0]   g_eff;
  logic [EXT_W-1:0]    pred_ext;
  logic [EXT_W-1:0]    pred_sel;
  logic [EXT_W-1:0]    margin;
  logic                active;
  logic [GX_W-1:0]     g_ext;
  logic [GX_W-1:0]     g_sel;
  logic [DATA_W-1:0]   grad_next;

  assign advance     = !valid_out || ready_out;
  assign ready_in    = advance && !rst;
  assign in_beat     = valid_in && ready_in;
  assign is_last_idx = (idx == LOG2_N'(IDX_LAST));
  // The first beat of a frame uses grad_in directly; later beats use the captured copy.
  assign g_eff       = (state == IDLE) ? grad_in : g_reg;

  // Margin sign in DATA_W+2 bits so neither negation nor subtraction can overflow.
  always_comb begin
    pred_ext = {{2{pred_in[DATA_W-1]}}, pred_in};
    pred_sel = target_pos ? pred_ext : -pred_ext;
    margin   = ONE_EXT - pred_sel;
    active   = !margin[EXT_W-1] && (margin != '0);
  end

  // Signed scale by 1/N, with negation widened so the most-negative g does not wrap.
  always_comb begin
    g_ext     = {s1_g[DATA_W-1], s1_g};
    g_sel     = s1_neg ? -g_ext : g_ext;
    grad_next = s1_active ? DATA_W'($signed(g_sel) >>> LOG2_N) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      g_reg     <= '0;
      s1_valid  <= 1'b0;
      s1_active <= 1'b0;
      s1_neg    <= 1'b0;
      s1_last   <= 1'b0;
      s1_g      <= '0;
      valid_out <= 1'b0;
      grad_out  <= '0;
      last_out  <= 1'b0;
    end else begin
      if (in_beat) begin
        if (state == IDLE) g_reg <= grad_in;
        if (is_last_idx) begin
          idx   <= '0;
          state <= IDLE;
        end else begin
          idx   <= idx + LOG2_N'(1);
          state <= RUN;
        end
      end
      if (advance) begin
        s1_valid  <= in_beat;
        s1_active <= active;
        s1_neg    <= target_pos;
        s1_last   <= is_last_idx;
        s1_g      <= g_eff;
        valid_out <= s1_valid;
        grad_out  <= s1_valid ? grad_next : '0;
        last_out  <= s1_valid && s1_last;
      end
    end
  end

`ifdef HINGE_BWD_VIOL_CNT_EN
  logic             s2_active;
  logic [CNT_W-1:0] acc;

  // Counts active elements as they retire; publishes on the frame's last output beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_active   <= 1'b0;
      acc         <= '0;
      viol_count  <= '0;
      count_valid <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      if (advance) s2_active <= s1_valid && s1_active;
      if (valid_out && ready_out) begin
        if (last_out) begin
          viol_count  <= acc + CNT_W'(s2_active);
          acc         <= '0;
          count_valid <= 1'b1;
        end else begin
          acc <= acc + CNT_W'(s2_active);
        end
      end
    end
  end
`else
  assign viol_count  = '0;
  assign count_valid = 1'b0;
`endif

endmodule

// File: tb/tb_hinge_loss_bwd.sv
// Directed bench for hinge_loss_bwd with N=4; counter expectations follow HINGE_BWD_VIOL_CNT_EN.
module tb_hinge_loss_bwd;

  localparam int unsigned DW = 32;
  localparam int unsigned LN = 2;
`ifdef HINGE_BWD_VIOL_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_in = 1'b0;
  logic          ready_in;
  logic [DW-1:0] pred_in = '0;
  logic          target_pos = 1'b0;
  logic [DW-1:0] grad_in = '0;
  logic          valid_out;
  logic          ready_out = 1'b1;
  logic [DW-1:0] grad_out;
  logic          last_out;
  logic [LN:0]   viol_count;
  logic          count_valid;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [DW-1:0] og[$];
  logic          ol[$];
  int            oc[$];
  int            ic[$];
  int            cv_v[$];
  int            cv_c[$];

  hinge_loss_bwd #(.DATA_W(DW), .LOG2_N(LN)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in),
    .pred_in(pred_in), .target_pos(target_pos), .grad_in(grad_in),
    .valid_out(valid_out), .ready_out(ready_out), .grad_out(grad_out),
    .last_out(last_out), .viol_count(viol_count), .count_valid(count_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record beats half a cycle before the edge that takes them.
  always @(negedge clk) begin
    if (valid_in && ready_in) ic.push_back(cyc);
    if (valid_out && ready_out && !rst) begin
      og.push_back(grad_out);
      ol.push_back(last_out);
      oc.push_back(cyc);
    end
    if (count_valid) begin
      cv_v.push_back(int'(viol_count));
      cv_c.push_back(cyc);
    end
  end

  task automatic clear_logs();
    og.delete(); ol.delete(); oc.delete(); ic.delete(); cv_v.delete(); cv_c.delete();
  endtask

  task automatic send(input logic [DW-1:0] p, input logic t, input logic [DW-1:0] g);
    bit ok = 1'b0;
    valid_in = 1'b1; pred_in = p; target_pos = t; grad_in = g;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready_in) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL send_accept ready_in=%b required 1", ready_in); end
  endtask

  task automatic settle();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (ready_in !== 1'b0) begin errors++; $display("FAIL rst_ready_in got %b want 0", ready_in); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid_out got %b want 0", valid_out); end
    checks++; if (grad_out !== '0) begin errors++; $display("FAIL rst_grad_out got %h want 0", grad_out); end
    checks++; if (last_out !== 1'b0) begin errors++; $display("FAIL rst_last_out got %b want 0", last_out); end
    checks++; if (viol_count !== '0) begin errors++; $display("FAIL rst_viol_count got %0d want 0", viol_count); end
    checks++; if (count_valid !== 1'b0) begin errors++; $display("FAIL rst_count_valid got %b want 0", count_valid); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [DW-1:0] e[4] = '{32'hFFFF_C000, 32'h0, 32'h0, 32'h0000_4000};
    clear_logs();
    send(32'h0000_8000, 1'b1, 32'h0001_0000);
    send(32'h0001_0000, 1'b1, 32'h0001_0000);
    send(32'hFFFE_0000, 1'b0, 32'h0001_0000);
    send(32'h0000_4000, 1'b0, 32'h0001_0000);
    settle();
    checks++; if (og.size() != 4) begin errors++; $display("FAIL basic_count got %0d want 4", og.size()); end
    for (int i = 0; i < 4 && i < og.size() && i < ic.size(); i++) begin
      checks++; if (og[i] !== e[i]) begin errors++; $display("FAIL basic_grad[%0d] got %h want %h", i, og[i], e[i]); end
      checks++; if (ol[i] !== (i == 3)) begin errors++; $display("FAIL basic_last[%0d] got %b want %b", i, ol[i], i == 3); end
      checks++; if (oc[i] - ic[i] != 2) begin errors++; $display("FAIL basic_latency[%0d] got %0d want 2", i, oc[i] - ic[i]); end
    end
    checks++; if (cv_v.size() != int'(CNT_ON)) begin errors++; $display("FAIL basic_cv_pulses got %0d want %0d", cv_v.size(), CNT_ON); end
    if (cv_v.size() > 0 && oc.size() == 4) begin
      checks++; if (cv_v[0] != 2) begin errors++; $display("FAIL basic_viol got %0d want 2", cv_v[0]); end
      checks++; if (cv_c[0] != oc[3] + 1) begin errors++; $display("FAIL basic_cv_timing got %0d want %0d", cv_c[0], oc[3] + 1); end
    end
    checks++; if (viol_count !== (CNT_ON ? 3'd2 : 3'd0)) begin errors++; $display("FAIL basic_viol_hold got %0d want %0d", viol_count, CNT_ON ? 2 : 0); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] e[4] = '{32'hFFFF_C000, 32'h0, 32'h0, 32'h0000_4000};
    clear_logs();
    fork
      begin
        send(32'h0000_8000, 1'b1, 32'h0001_0000);
        send(32'h0001_0000, 1'b1, 32'h0001_0000);
        send(32'hFFFE_0000, 1'b0, 32'h0001_0000);
        send(32'h0000_4000, 1'b0, 32'h0001_0000);
      end
      begin
        bit seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
          @(posedge clk); #1;
          if (valid_out) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL bp_first_valid got 0 want 1"); end
        ready_out = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          checks++; if (grad_out !== 32'hFFFF_C000) begin errors++; $display("FAIL bp_hold_grad[%0d] got %h want ffffc000", s, grad_out); end
          checks++; if (ready_in !== 1'b0) begin errors++; $display("FAIL bp_ready_in[%0d] got %b want 0", s, ready_in); end
          @(posedge clk); #1;
        end
        ready_out = 1'b1;
      end
    join
    settle();
    checks++; if (og.size() != 4) begin errors++; $display("FAIL bp_count got %0d want 4", og.size()); end
    for (int i = 0; i < 4 && i < og.size(); i++) begin
      checks++; if (og[i] !== e[i]) begin errors++; $display("FAIL bp_grad[%0d] got %h want %h", i, og[i], e[i]); end
      checks++; if (ol[i] !== (i == 3)) begin errors++; $display("FAIL bp_last[%0d] got %b want %b", i, ol[i], i == 3); end
    end
    checks++; if (viol_count !== (CNT_ON ? 3'd2 : 3'd0)) begin errors++; $display("FAIL bp_viol got %0d want %0d", viol_count, CNT_ON ? 2 : 0); end
  endtask

  task automatic test_back_to_back_capture();
    logic [DW-1:0] e[8] = '{32'hFFFF_C000, 32'hFFFF_C000, 32'h0000_4000, 32'hFFFF_C000,
                            32'hFFFF_0000, 32'h0, 32'h0, 32'h0001_0000};
    int ev[2] = '{4, 2};
    clear_logs();
    send(32'h0000_8000, 1'b1, 32'h0001_0000);
    send(32'h0000_8000, 1'b1, 32'h0004_0000);
    send(32'h0000_4000, 1'b0, 32'h0004_0000);
    send(32'h0000_8000, 1'b1, 32'h0004_0000);
    send(32'h0000_8000, 1'b1, 32'h0004_0000);
    send(32'h0001_0000, 1'b1, 32'h0001_0000);
    send(32'hFFFE_0000, 1'b0, 32'h0001_0000);
    send(32'h0000_4000, 1'b0, 32'h0001_0000);
    settle();
    checks++; if (og.size() != 8) begin errors++; $display("FAIL b2b_count got %0d want 8", og.size()); end
    for (int i = 0; i < 8 && i < og.size(); i++) begin
      checks++; if (og[i] !== e[i]) begin errors++; $display("FAIL b2b_grad[%0d] got %h want %h", i, og[i], e[i]); end
      checks++; if (ol[i] !== (i == 3 || i == 7)) begin errors++; $display("FAIL b2b_last[%0d] got %b want %b", i, ol[i], i == 3 || i == 7); end
    end
    if (oc.size() == 8) begin
      checks++; if (oc[7] - oc[0] != 7) begin errors++; $display("FAIL b2b_bubble span got %0d want 7", oc[7] - oc[0]); end
    end
    checks++; if (cv_v.size() != (CNT_ON ? 2 : 0)) begin errors++; $display("FAIL b2b_cv_pulses got %0d want %0d", cv_v.size(), CNT_ON ? 2 : 0); end
    for (int f = 0; f < 2 && f < cv_v.size(); f++) begin
      checks++; if (cv_v[f] != ev[f]) begin errors++; $display("FAIL b2b_viol[%0d] got %0d want %0d", f, cv_v[f], ev[f]); end
    end
  endtask

  task automatic test_extreme_g();
    logic [DW-1:0] e[4] = '{32'hE000_0000, 32'h2000_0000, 32'h0, 32'h0};
    clear_logs();
    send(32'h0000_0000, 1'b0, 32'h8000_0000);
    send(32'h0000_0000, 1'b1, 32'h8000_0000);
    send(32'h0001_0000, 1'b1, 32'h8000_0000);
    send(32'hFFFF_0000, 1'b0, 32'h8000_0000);
    settle();
    checks++; if (og.size() != 4) begin errors++; $display("FAIL ext_count got %0d want 4", og.size()); end
    for (int i = 0; i < 4 && i < og.size(); i++) begin
      checks++; if (og[i] !== e[i]) begin errors++; $display("FAIL ext_grad[%0d] got %h want %h", i, og[i], e[i]); end
    end
    checks++; if (viol_count !== (CNT_ON ? 3'd2 : 3'd0)) begin errors++; $display("FAIL ext_viol got %0d want %0d", viol_count, CNT_ON ? 2 : 0); end
  endtask

  task automatic test_reset_mid_frame();
    logic [DW-1:0] e[4] = '{32'hFFFF_C000, 32'h0, 32'h0, 32'h0000_4000};
    clear_logs();
    send(32'h0000_8000, 1'b1, 32'h0001_0000);
    send(32'h0000_8000, 1'b1, 32'h0001_0000);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rmid_valid_out got %b want 0", valid_out); end
    checks++; if (grad_out !== '0) begin errors++; $display("FAIL rmid_grad_out got %h want 0", grad_out); end
    checks++; if (last_out !== 1'b0) begin errors++; $display("FAIL rmid_last_out got %b want 0", last_out); end
    checks++; if (ready_in !== 1'b0) begin errors++; $display("FAIL rmid_ready_in got %b want 0", ready_in); end
    checks++; if (viol_count !== '0) begin errors++; $display("FAIL rmid_viol got %0d want 0", viol_count); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cv_v.size() != 0) begin errors++; $display("FAIL rmid_no_cv got %0d want 0", cv_v.size()); end
    clear_logs();
    send(32'h0000_8000, 1'b1, 32'h0001_0000);
    send(32'h0001_0000, 1'b1, 32'h0001_0000);
    send(32'hFFFE_0000, 1'b0, 32'h0001_0000);
    send(32'h0000_4000, 1'b0, 32'h0001_0000);
    settle();
    checks++; if (og.size() != 4) begin errors++; $display("FAIL rmid_count got %0d want 4", og.size()); end
    for (int i = 0; i < 4 && i < og.size(); i++) begin
      checks++; if (og[i] !== e[i]) begin errors++; $display("FAIL rmid_grad[%0d] got %h want %h", i, og[i], e[i]); end
      checks++; if (ol[i] !== (i == 3)) begin errors++; $display("FAIL rmid_last[%0d] got %b want %b", i, ol[i], i == 3); end
    end
    checks++; if (cv_v.size() != int'(CNT_ON)) begin errors++; $display("FAIL rmid_cv_pulses got %0d want %0d", cv_v.size(), CNT_ON); end
    if (cv_v.size() > 0) begin
      checks++; if (cv_v[0] != 2) begin errors++; $display("FAIL rmid_viol_frame got %0d want 2", cv_v[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back_capture();
    test_extreme_g();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
